// File: rtl/ird_sequencer.sv
// -----------------------------------------------------------------------------
// ird_sequencer
//
// Sequences the instruction-decode (IRD) dispatch ROMs. The microsequencer
// raises IRD1 (new opcode) or IRDX (next operand specifier) requests. The
// sequencer waits until the prefetch buffer has the byte, then runs a single
// dispatch cycle. In that cycle the ROM block turns IR, IRD1, the specifier
// counter and the register-mode flag into a control-store dispatch address.
//
// Parameters
//   MAX_SPEC        number of IRDX dispatches allowed per instruction (1..7)
//
// Ports
//   clk_h           system clock, rising edge
//   reset_l         synchronous active-low reset
//   ird_req_h       IRD1 request (level, held until ird_done_h)
//   irdx_req_h      IRDX request (level, held until ird_done_h)
//   abort_h         synchronous abort of the current decode
//   xbuf_valid_h    prefetch byte on xbuf_h is valid
//   xbuf_h          current prefetch byte
//   xbuf_consume_h  pulse: prefetch byte consumed
//   ir_h            latched opcode
//   en_ird_rom_h    ROM enable, dispatch cycle only
//   ird1_h/ird1_l   IRD1 dispatch in progress (true / complement)
//   ird_ctr_h       specifier index
//   reg_mode_h      current specifier is register mode
//   ird_done_h      dispatch address valid this cycle
//   ird_stall_h     request pending, byte not yet available
//   seq_err_h       pulse: illegal request seen on the previous edge
// -----------------------------------------------------------------------------
module ird_sequencer #(
   parameter int unsigned MAX_SPEC = 6
) (
   input  logic       clk_h,
   input  logic       reset_l,
   input  logic       ird_req_h,
   input  logic       irdx_req_h,
   input  logic       abort_h,
   input  logic       xbuf_valid_h,
   input  logic [7:0] xbuf_h,
   output logic       xbuf_consume_h,
   output logic [7:0] ir_h,
   output logic       en_ird_rom_h,
   output logic       ird1_h,
   output logic       ird1_l,
   output logic [2:0] ird_ctr_h,
   output logic       reg_mode_h,
   output logic       ird_done_h,
   output logic       ird_stall_h,
   output logic       seq_err_h
);

   localparam logic [2:0] MaxSpec = 3'(MAX_SPEC);

   // Register-mode specifiers carry 0x5 in the upper nibble.
   localparam logic [3:0] RegModeNibble = 4'h5;

   typedef enum logic [2:0] {
      StIdle,
      StWait1,
      StDisp1,
      StSpec,
      StWaitX,
      StDispX
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [2:0] ctr_q, ctr_d;
   logic       reg_mode_q, reg_mode_d;
   logic       seq_err_q, seq_err_d;

   // Request decode shared by IDLE and SPEC.
   logic       go_ird1;
   logic       go_irdx;
   logic       enter_disp1;
   logic       enter_dispx;
   logic       in_dispatch;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_h) begin
      if (!reset_l) begin
         state_q    <= StIdle;
         ir_q       <= 8'h00;
         ctr_q      <= 3'd0;
         reg_mode_q <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         ctr_q      <= ctr_d;
         reg_mode_q <= reg_mode_d;
         seq_err_q  <= seq_err_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      ctr_d       = ctr_q;
      reg_mode_d  = reg_mode_q;
      seq_err_d   = 1'b0;
      go_ird1     = 1'b0;
      go_irdx     = 1'b0;
      enter_disp1 = 1'b0;
      enter_dispx = 1'b0;

      if (abort_h) begin
         // Abort wins over any request; IR is kept for fault reporting.
         state_d    = StIdle;
         ctr_d      = 3'd0;
         reg_mode_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ird_req_h) begin
                  go_ird1 = 1'b1;
               end else if (irdx_req_h) begin
                  // No opcode decoded yet, so a specifier request is illegal.
                  seq_err_d = 1'b1;
               end
            end

            StSpec: begin
               if (ird_req_h) begin
                  go_ird1 = 1'b1;
               end else if (irdx_req_h) begin
                  if (ctr_q < MaxSpec) begin
                     go_irdx = 1'b1;
                  end else begin
                     seq_err_d = 1'b1;
                  end
               end
            end

            StWait1: begin
               if (xbuf_valid_h) begin
                  enter_disp1 = 1'b1;
               end
            end

            StWaitX: begin
               if (xbuf_valid_h) begin
                  enter_dispx = 1'b1;
               end
            end

            StDisp1: begin
               state_d = StSpec;
            end

            StDispX: begin
               state_d = StSpec;
               if (ctr_q != MaxSpec) begin
                  ctr_d = ctr_q + 3'd1;
               end
            end

            default: begin
               state_d = StIdle;
            end
         endcase

         // Accepted requests go straight to dispatch if the byte is already there.
         if (go_ird1) begin
            if (xbuf_valid_h) begin
               enter_disp1 = 1'b1;
            end else begin
               state_d = StWait1;
            end
         end
         if (go_irdx) begin
            if (xbuf_valid_h) begin
               enter_dispx = 1'b1;
            end else begin
               state_d = StWaitX;
            end
         end

         // IR, counter and mode are loaded on the entry edge so they are stable
         // for the whole dispatch cycle when the ROMs sample them.
         if (enter_disp1) begin
            state_d = StDisp1;
            ir_d    = xbuf_h;
            ctr_d   = 3'd0;
         end
         if (enter_dispx) begin
            state_d    = StDispX;
            reg_mode_d = (xbuf_h[7:4] == RegModeNibble);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   always_comb begin
      // An abort in the dispatch cycle cancels the dispatch outright.
      in_dispatch    = ((state_q == StDisp1) || (state_q == StDispX)) && !abort_h;
      en_ird_rom_h   = in_dispatch;
      ird_done_h     = in_dispatch;
      xbuf_consume_h = in_dispatch && xbuf_valid_h;
      ird1_h         = (state_q == StDisp1) && !abort_h;
      ird1_l         = !ird1_h;
      ird_stall_h    = (state_q == StWait1) || (state_q == StWaitX);
   end

   assign ir_h       = ir_q;
   assign ird_ctr_h  = ctr_q;
   assign reg_mode_h = reg_mode_q;
   assign seq_err_h  = seq_err_q;

   // --------------------------------------------------------------------------
   // Invariants
   // --------------------------------------------------------------------------
   a_consume_valid : assert property (@(posedge clk_h) disable iff (!reset_l)
      xbuf_consume_h |-> xbuf_valid_h);

   a_ctr_range : assert property (@(posedge clk_h) disable iff (!reset_l)
      ird_ctr_h <= MaxSpec);

endmodule

// File: tb/tb_ird_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ird_sequencer
//
// Drives ird_sequencer with directed sequences followed by random traffic.
// A transaction-level model predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_ird_sequencer;

   localparam int unsigned MaxSpec = 6;

   logic       clk_h = 1'b0;
   logic       reset_l;
   logic       ird_req_h;
   logic       irdx_req_h;
   logic       abort_h;
   logic       xbuf_valid_h;
   logic [7:0] xbuf_h;
   logic       xbuf_consume_h;
   logic [7:0] ir_h;
   logic       en_ird_rom_h;
   logic       ird1_h;
   logic       ird1_l;
   logic [2:0] ird_ctr_h;
   logic       reg_mode_h;
   logic       ird_done_h;
   logic       ird_stall_h;
   logic       seq_err_h;

   always #5 clk_h = ~clk_h;

   ird_sequencer #(
      .MAX_SPEC(MaxSpec)
   ) u_dut (
      .clk_h         (clk_h),
      .reset_l       (reset_l),
      .ird_req_h     (ird_req_h),
      .irdx_req_h    (irdx_req_h),
      .abort_h       (abort_h),
      .xbuf_valid_h  (xbuf_valid_h),
      .xbuf_h        (xbuf_h),
      .xbuf_consume_h(xbuf_consume_h),
      .ir_h          (ir_h),
      .en_ird_rom_h  (en_ird_rom_h),
      .ird1_h        (ird1_h),
      .ird1_l        (ird1_l),
      .ird_ctr_h     (ird_ctr_h),
      .reg_mode_h    (reg_mode_h),
      .ird_done_h    (ird_done_h),
      .ird_stall_h   (ird_stall_h),
      .seq_err_h     (seq_err_h)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Model: an instruction is "open" after IRD1 completes; a request is either
   // waiting for its byte (m_wait) or being dispatched (m_disp). 1=IRD1, 2=IRDX.
   bit         m_open;
   int         m_wait;
   int         m_disp;
   logic [7:0] m_ir;
   int         m_ctr;
   bit         m_reg;
   bit         m_err;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit disp;
      disp = (m_disp != 0) && !abort_h;
      check_val("ir", 32'(ir_h), 32'(m_ir));
      check_val("ctr", 32'(ird_ctr_h), 32'(m_ctr));
      check_val("reg_mode", 32'(reg_mode_h), 32'(m_reg));
      check_val("en_rom", 32'(en_ird_rom_h), 32'(disp));
      check_val("done", 32'(ird_done_h), 32'(disp));
      check_val("ird1", 32'(ird1_h), 32'(disp && m_disp == 1));
      check_val("ird1_l", 32'(ird1_l), 32'(!(disp && m_disp == 1)));
      check_val("consume", 32'(xbuf_consume_h), 32'(disp && xbuf_valid_h));
      check_val("stall", 32'(ird_stall_h), 32'(m_wait != 0));
      check_val("seq_err", 32'(seq_err_h), 32'(m_err));
   endtask

   task automatic launch(input int kind);
      if (xbuf_valid_h) begin
         m_wait = 0;
         m_disp = kind;
         if (kind == 1) begin
            m_ir  = xbuf_h;
            m_ctr = 0;
         end else begin
            m_reg = (xbuf_h[7:4] == 4'h5);
         end
      end else begin
         m_wait = kind;
      end
   endtask

   task automatic model_edge();
      if (!reset_l) begin
         m_open = 0; m_wait = 0; m_disp = 0; m_ir = 8'h00; m_ctr = 0; m_reg = 0; m_err = 0;
      end else if (abort_h) begin
         m_open = 0; m_wait = 0; m_disp = 0; m_ctr = 0; m_reg = 0; m_err = 0;
      end else begin
         m_err = 0;
         if (m_disp != 0) begin
            if (m_disp == 2 && m_ctr < int'(MaxSpec)) m_ctr++;
            m_disp = 0;
            m_open = 1;
         end else if (m_wait != 0) begin
            if (xbuf_valid_h) launch(m_wait);
         end else if (ird_req_h) begin
            launch(1);
         end else if (irdx_req_h) begin
            if (m_open && m_ctr < int'(MaxSpec)) launch(2);
            else m_err = 1;
         end
      end
   endtask

   // Check outputs mid-cycle, advance the model on the edge, return just after it.
   task automatic step();
      @(negedge clk_h);
      check_outputs();
      @(posedge clk_h);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic ird, input logic irdx, input logic abrt, input logic vld,
                        input logic [7:0] byte_v);
      ird_req_h    = ird;
      irdx_req_h   = irdx;
      abort_h      = abrt;
      xbuf_valid_h = vld;
      xbuf_h       = byte_v;
   endtask

   // One request with the byte present, then the dispatch cycle.
   task automatic quick(input logic ird, input logic [7:0] byte_v);
      drive(ird, !ird, 1'b0, 1'b1, byte_v);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, byte_v);
      step();
   endtask

   initial begin
      logic [7:0] spec_bytes [3];
      spec_bytes[0] = 8'h51;
      spec_bytes[1] = 8'h8F;
      spec_bytes[2] = 8'h52;

      reset_l = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      m_open = 0; m_wait = 0; m_disp = 0; m_ir = 8'hxx; m_ctr = 0; m_reg = 0; m_err = 0;
      @(posedge clk_h);
      model_edge();
      #1;
      step();
      reset_l = 1'b1;
      check_val("rst_ir", 32'(ir_h), 32'h00);
      check_val("rst_ird1_l", 32'(ird1_l), 32'h1);
      for (int i = 0; i < 3; i++) step();

      // IRD1 with byte available: dispatch one clock later.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hC1);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC1);
      check_val("ird1_en", 32'(en_ird_rom_h), 32'h1);
      check_val("ird1_hi", 32'(ird1_h), 32'h1);
      check_val("ird1_ir", 32'(ir_h), 32'hC1);
      check_val("ird1_ctr", 32'(ird_ctr_h), 32'h0);
      check_val("ird1_consume", 32'(xbuf_consume_h), 32'h1);
      step();

      // Three specifiers: register, non-register, register.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b1, spec_bytes[i]);
         step();
         drive(1'b0, 1'b0, 1'b0, 1'b1, spec_bytes[i]);
         check_val("spec_ctr", 32'(ird_ctr_h), 32'(i));
         check_val("spec_reg", 32'(reg_mode_h), 32'(i != 1));
         step();
      end
      check_val("spec_ctr_after", 32'(ird_ctr_h), 32'h3);

      // Specifier request that stalls for four cycles.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
      step();
      for (int i = 0; i < 3; i++) step();
      check_val("stall_hi", 32'(ird_stall_h), 32'h1);
      xbuf_valid_h = 1'b1;
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
      check_val("stall_disp", 32'(en_ird_rom_h), 32'h1);
      step();

      // Fill up to MAX_SPEC, then one more is illegal.
      while (ird_ctr_h < 3'(MaxSpec)) quick(1'b0, 8'h60);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h61);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h61);
      check_val("max_err", 32'(seq_err_h), 32'h1);
      check_val("max_no_rom", 32'(en_ird_rom_h), 32'h0);
      step();

      // Abort to IDLE, then IRDX from IDLE is illegal.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h51);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h51);
      check_val("idle_err", 32'(seq_err_h), 32'h1);
      step();

      // Abort in WAITX.
      quick(1'b1, 8'hA0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h51);
      step();
      abort_h = 1'b1;
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check_val("abortx_ctr", 32'(ird_ctr_h), 32'h0);
      check_val("abortx_stall", 32'(ird_stall_h), 32'h0);
      step();

      // Abort together with IRD1 in SPEC.
      quick(1'b1, 8'hA1);
      quick(1'b0, 8'h52);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hB2);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hB2);
      check_val("abort1_ctr", 32'(ird_ctr_h), 32'h0);
      check_val("abort1_en", 32'(en_ird_rom_h), 32'h0);
      check_val("abort1_ir", 32'(ir_h), 32'hA1);
      step();

      // Reset in DISPX.
      quick(1'b1, 8'hA2);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h53);
      step();
      reset_l = 1'b0;
      step();
      reset_l = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check_val("rstx_ir", 32'(ir_h), 32'h00);
      check_val("rstx_ctr", 32'(ird_ctr_h), 32'h0);
      check_val("rstx_reg", 32'(reg_mode_h), 32'h0);
      check_val("rstx_ird1_l", 32'(ird1_l), 32'h1);
      check_val("rstx_en", 32'(en_ird_rom_h), 32'h0);
      step();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         reset_l      = ($urandom_range(0, 199) != 0);
         ird_req_h    = ($urandom_range(0, 99) < 20);
         irdx_req_h   = ($urandom_range(0, 99) < 40);
         abort_h      = ($urandom_range(0, 99) < 3);
         xbuf_valid_h = ($urandom_range(0, 99) < 60);
         xbuf_h       = 8'($urandom);
         if ($urandom_range(0, 3) == 0) xbuf_h[7:4] = 4'h5;
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ird_sequencer.md
Name: ird_sequencer

Overview:
Sequences the instruction-decode (IRD) dispatch ROMs for the CPU. It accepts IRD1 (new opcode) and IRDX (next operand specifier) requests from the microsequencer and waits for the instruction byte in the prefetch buffer. It latches the opcode into IR and drives the ROM enable, the IRD1 select, the specifier counter and the register-mode flag. The ROM block uses these signals to produce the control-store dispatch address.

Parameters:
MAX_SPEC, 6, number of IRDX dispatches permitted per instruction (1..7).

Ports:
clk_h  in  1  system clock; all state changes on rising edge
reset_l  in  1  synchronous active-low reset
ird_req_h  in  1  microcode requests IRD1 dispatch (level, held until ird_done_h)
irdx_req_h  in  1  microcode requests next specifier dispatch (level, held until ird_done_h)
abort_h  in  1  synchronous abort of the current decode (fault/interrupt)
xbuf_valid_h  in  1  prefetch buffer byte on xbuf_h is valid
xbuf_h  in  8  current prefetch buffer byte
xbuf_consume_h  out  1  one-cycle pulse: byte on xbuf_h consumed
ir_h  out  8  latched opcode
en_ird_rom_h  out  1  ROM enable, high only in dispatch cycle
ird1_h  out  1  IRD1 dispatch in progress
ird1_l  out  1  complement of ird1_h
ird_ctr_h  out  3  specifier index
reg_mode_h  out  1  current specifier is register mode
ird_done_h  out  1  dispatch address valid this cycle
ird_stall_h  out  1  request pending, byte not yet available
seq_err_h  out  1  one-cycle pulse: illegal request

Behaviour:
- Reset (reset_l=0 at an edge): state IDLE, ir_h=0, ird_ctr_h=0, reg_mode_h=0, all _h outputs 0, ird1_l=1. Reset overrides every input, including a decode that is in progress.
- States: IDLE, WAIT1, DISP1, SPEC, WAITX, DISPX.
- IDLE / SPEC, ird_req_h=1:
  - goes to DISP1 if xbuf_valid_h=1, else to WAIT1.
  - ird_req_h has priority over a simultaneous irdx_req_h.
- SPEC, irdx_req_h=1 (no ird_req_h):
  - if ird_ctr_h < MAX_SPEC, goes to DISPX if xbuf_valid_h=1, else to WAITX.
  - if ird_ctr_h = MAX_SPEC, pulses seq_err_h, stays in SPEC, no dispatch.
- IDLE, irdx_req_h=1 alone: pulses seq_err_h, stays in IDLE.
- WAIT1 / WAITX:
  - ird_stall_h=1.
  - moves to DISP1 / DISPX on the first cycle with xbuf_valid_h=1.
- Entering DISP1: on that edge, ir_h<=xbuf_h and ird_ctr_h<=0.
- DISP1 (exactly one cycle): en_ird_rom_h=1, ird1_h=1, ird1_l=0, ird_done_h=1, xbuf_consume_h=1. Next state SPEC.
- Entering DISPX: on that edge, reg_mode_h <= (xbuf_h[7:4]==4'h5).
- DISPX (exactly one cycle): en_ird_rom_h=1, ird1_h=0, ird_done_h=1, xbuf_consume_h=1. On exit, ird_ctr_h increments by 1, saturating at MAX_SPEC. Next state SPEC.
- Latency: a request with byte available gives the dispatch cycle one clock after the request is sampled; each cycle without a byte adds one clock.
- reg_mode_h, ir_h and ird_ctr_h hold between dispatches; they are stable during the dispatch cycle and the ROMs sample them then.
- abort_h=1 in any state: next state IDLE, ird_ctr_h<=0, reg_mode_h<=0, ir_h held, no dispatch and no consume that cycle. abort_h beats a simultaneous request.
- ird_req_h while in SPEC (next instruction) starts IRD1 and clears the counter; no error.
- A request must drop in the cycle after ird_done_h. If still high, it is treated as a new request.
- xbuf_consume_h is never asserted without xbuf_valid_h in the same dispatch cycle.

Test Plan:
- Reset then idle: ird1_l=1; ir_h=0x00, ird_ctr_h=0, en_ird_rom_h=0 on every cycle.
- ird_req_h with xbuf_valid_h=1 and xbuf_h=0xC1 -> next cycle: en_ird_rom_h=1, ird1_h=1, ir_h=0xC1, ird_ctr_h=0, xbuf_consume_h=1; then state SPEC.
- After IRD1, issue three irdx_req_h with xbuf_h=0x51, 0x8F, 0x52 -> dispatches at ird_ctr_h=0, 1, 2 with reg_mode_h=1, 0, 1; ird_ctr_h=3 afterwards.
- irdx_req_h with xbuf_valid_h=0 for 4 cycles then 1 -> ird_stall_h=1 for 4 cycles, dispatch on the 5th, exactly one consume pulse.
- Drive MAX_SPEC=6 dispatches then a 7th irdx_req_h -> seq_err_h pulse, no en_ird_rom_h; irdx_req_h from IDLE -> seq_err_h pulse.
- abort_h asserted in WAITX, and separately simultaneous with ird_req_h in SPEC -> IDLE next cycle, ird_ctr_h=0, no dispatch. reset_l low in DISPX -> all outputs at reset values next cycle.
